// File: rtl/reg_pkg.sv
// Shared constants and helper for the reg_pipe register pipeline.
package reg_pkg;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_DEPTH = 4;

   // Ceiling log2; clog2(1) = 0, clog2(5) = 3.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/reg_stage.sv
// One pipeline stage: valid flag plus data word with load, clear and hold.
module reg_stage
   import reg_pkg::*;
#(
   parameter int unsigned      WIDTH   = DEF_WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic             v_i,
   input  logic [WIDTH-1:0] d_i,
   output logic             v_o,
   output logic [WIDTH-1:0] d_o
);

   logic             v_q, v_d;
   logic [WIDTH-1:0] d_q, d_d;

   // Clear beats load; data only follows a valid incoming word, so bubbles never toggle it.
   always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (clr_i) begin
         v_d = 1'b0;
      end else if (load_i) begin
         v_d = v_i;
         if (v_i) d_d = d_i;
      end
   end

   // Stage registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= 1'b0;
         d_q <= RST_VAL;
      end else begin
         v_q <= v_d;
         d_q <= d_d;
      end
   end

   assign v_o = v_q;
   assign d_o = d_q;

endmodule

// File: rtl/reg_pipe.sv
// Valid/ready register pipeline with bubble collapse, flush and global enable.
// Optional occupancy output enabled by defining REG_PIPE_OCC_EN.
module reg_pipe
   import reg_pkg::*;
#(
   parameter int unsigned      WIDTH   = DEF_WIDTH,
   parameter int unsigned      DEPTH   = DEF_DEPTH,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
`ifdef REG_PIPE_OCC_EN
   ,
   output logic [clog2(DEPTH+1)-1:0] occ
`endif
);

   logic [DEPTH-1:0] stg_v_q;
   logic [WIDTH-1:0] stg_d_q  [DEPTH];
   logic [DEPTH-1:0] stg_v_in;
   logic [WIDTH-1:0] stg_d_in [DEPTH];
   logic [DEPTH-1:0] can_load;
   logic [DEPTH-1:0] stg_load;
   logic             in_fire;
   logic             clr;

   // A stage can load unless it and every stage after it are full and the output is stalled.
   // Computed as a running "blocked" term from the output end to avoid a self-referencing vector.
   always_comb begin : p_can_load
      logic blocked;
      blocked  = ~out_ready;
      can_load = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         blocked                = blocked & stg_v_q[DEPTH-1-k];
         can_load[DEPTH-1-k]    = ~blocked;
      end
   end

   assign in_ready = en & can_load[0];
   assign in_fire  = in_valid & in_ready;
   assign clr      = en & flush;
   assign stg_load = {DEPTH{en}} & can_load;

   // Each stage is fed by its predecessor; stage 0 by the accepted upstream word.
   always_comb begin
      stg_v_in    = '0;
      stg_v_in[0] = in_fire;
      stg_d_in[0] = in_data;
      for (int unsigned k = 1; k < DEPTH; k++) begin
         stg_v_in[k] = stg_v_q[k-1];
         stg_d_in[k] = stg_d_q[k-1];
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      reg_stage #(
         .WIDTH   (WIDTH),
         .RST_VAL (RST_VAL)
      ) u_stage (
         .clk    (clk),
         .rst    (rst),
         .clr_i  (clr),
         .load_i (stg_load[g]),
         .v_i    (stg_v_in[g]),
         .d_i    (stg_d_in[g]),
         .v_o    (stg_v_q[g]),
         .d_o    (stg_d_q[g])
      );
   end

   assign out_valid = stg_v_q[DEPTH-1];
   assign out_data  = stg_d_q[DEPTH-1];

`ifdef REG_PIPE_OCC_EN
   localparam int unsigned OCC_W = clog2(DEPTH+1);

   logic [OCC_W-1:0] occ_q, occ_d;
   logic             out_fire;

   assign out_fire = en & stg_v_q[DEPTH-1] & out_ready;

   // Occupancy tracks the number of set valid flags.
   always_comb begin
      occ_d = occ_q;
      if (clr) begin
         occ_d = '0;
      end else if (in_fire && !out_fire) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (out_fire && !in_fire) begin
         occ_d = occ_q - OCC_W'(1);
      end
   end

   // Occupancy register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) occ_q <= '0;
      else     occ_q <= occ_d;
   end

   assign occ = occ_q;
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// Self-checking bench for reg_pipe (WIDTH=32, DEPTH=4, RST_VAL=0xDEAD).
// Reference model: a queue of accepted words, each carrying the number of
// enabled edges it has spent inside the pipe. The oldest word is visible at
// the output once that age reaches DEPTH-1.
module tb_reg_pipe;

   localparam int unsigned W     = 32;
   localparam int unsigned DEPTH = 4;
   localparam logic [W-1:0] RV   = 32'hDEAD;

   logic         clk;
   logic         rst, en, flush, in_valid, out_ready;
   logic [W-1:0] in_data;
   logic         in_ready, out_valid;
   logic [W-1:0] out_data;
`ifdef REG_PIPE_OCC_EN
   logic [2:0]   occ;
`endif

   reg_pipe #(
      .WIDTH   (W),
      .DEPTH   (DEPTH),
      .RST_VAL (RV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
`ifdef REG_PIPE_OCC_EN
      ,
      .occ       (occ)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned passes = 0;

   typedef struct {
      logic [W-1:0] data;
      int unsigned  age;
   } word_t;

   word_t        q[$];
   logic [W-1:0] last_out;
   bit           mv = 1'b0;

   typedef struct {
      bit r, e, f, iv;
      logic [W-1:0] id;
      bit orr, chk, ir, ov;
      logic [W-1:0] od;
   } vec_t;

   function automatic vec_t mk(bit r, bit e, bit f, bit iv, logic [W-1:0] id, bit orr,
                               bit c, bit ir, bit ov, logic [W-1:0] od);
      vec_t v;
      v.r = r; v.e = e; v.f = f; v.iv = iv; v.id = id; v.orr = orr;
      v.chk = c; v.ir = ir; v.ov = ov; v.od = od;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Apply inputs, then compare outputs against the model.
   task automatic drive(input bit r, input bit e, input bit f, input bit iv,
                        input logic [W-1:0] id, input bit orr);
      bit ev;
      rst = r; en = e; flush = f; in_valid = iv; in_data = id; out_ready = orr;
      #1;
      if (mv) begin
         ev = (q.size() > 0) && (q[0].age >= DEPTH-1);
         chk("in_ready", in_ready, e && ((q.size() < DEPTH) || orr));
         chk("out_valid", out_valid, ev);
         chk("out_data", out_data, ev ? q[0].data : last_out);
`ifdef REG_PIPE_OCC_EN
         chk("occ", occ, q.size());
`endif
      end
   endtask

   // Take one clock edge and update the model.
   task automatic advance();
      bit    pop, acc, ir_e;
      word_t w;
      ir_e = en && ((q.size() < DEPTH) || out_ready);
      pop  = (q.size() > 0) && (q[0].age >= DEPTH-1) && out_ready;
      acc  = in_valid && ir_e;
      @(posedge clk);
      if (rst) begin
         q.delete();
         last_out = RV;
         mv       = 1'b1;
      end else if (mv && en) begin
         if (flush) begin
            q.delete();
         end else begin
            if (pop) w = q.pop_front();
            for (int k = 0; k < q.size(); k++) q[k].age = q[k].age + 1;
            if (acc) begin
               w.data = in_data;
               w.age  = 0;
               q.push_back(w);
            end
         end
      end
      if ((q.size() > 0) && (q[0].age >= DEPTH-1)) last_out = q[0].data;
      @(negedge clk);
   endtask

   task automatic step(input bit r, input bit e, input bit f, input bit iv,
                       input logic [W-1:0] id, input bit orr);
      drive(r, e, f, iv, id, orr);
      advance();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   vec_t         tbl[12];
   logic [W-1:0] got[$];
   logic [W-1:0] exp34[$];
   int unsigned  n;

   initial begin
      rst = 1'b0; en = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      last_out = RV;
      @(negedge clk);

      // Reset, then 0x11/0x22/0x33 back-to-back; en=0 and reset-with-en=0 at the end.
      tbl[0]  = mk(1'b1,1'b1,1'b0,1'b0,32'h0 ,1'b1, 1'b0,1'b0,1'b0,32'h0);
      tbl[1]  = mk(1'b0,1'b1,1'b0,1'b1,32'h11,1'b1, 1'b1,1'b1,1'b0,32'hDEAD);
      tbl[2]  = mk(1'b0,1'b1,1'b0,1'b1,32'h22,1'b1, 1'b1,1'b1,1'b0,32'hDEAD);
      tbl[3]  = mk(1'b0,1'b1,1'b0,1'b1,32'h33,1'b1, 1'b1,1'b1,1'b0,32'hDEAD);
      tbl[4]  = mk(1'b0,1'b1,1'b0,1'b0,32'h0 ,1'b1, 1'b1,1'b1,1'b0,32'hDEAD);
      tbl[5]  = mk(1'b0,1'b1,1'b0,1'b0,32'h0 ,1'b1, 1'b1,1'b1,1'b1,32'h11);
      tbl[6]  = mk(1'b0,1'b1,1'b0,1'b0,32'h0 ,1'b1, 1'b1,1'b1,1'b1,32'h22);
      tbl[7]  = mk(1'b0,1'b1,1'b0,1'b0,32'h0 ,1'b1, 1'b1,1'b1,1'b1,32'h33);
      tbl[8]  = mk(1'b0,1'b1,1'b0,1'b0,32'h0 ,1'b1, 1'b1,1'b1,1'b0,32'h33);
      tbl[9]  = mk(1'b0,1'b0,1'b0,1'b1,32'h44,1'b1, 1'b1,1'b0,1'b0,32'h33);
      tbl[10] = mk(1'b1,1'b0,1'b0,1'b0,32'h0 ,1'b1, 1'b1,1'b0,1'b0,32'h33);
      tbl[11] = mk(1'b0,1'b1,1'b0,1'b0,32'h0 ,1'b0, 1'b1,1'b1,1'b0,32'hDEAD);

      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].r, tbl[i].e, tbl[i].f, tbl[i].iv, tbl[i].id, tbl[i].orr);
         if (tbl[i].chk) begin
            chk("tbl_in_ready", in_ready, tbl[i].ir);
            chk("tbl_out_valid", out_valid, tbl[i].ov);
            chk("tbl_out_data", out_data, tbl[i].od);
         end
         advance();
      end

      // Backpressure: 6 offers, only 4 fit; then drain in order.
      step(1'b1,1'b1,1'b0,1'b0,32'h0,1'b1);
      n = 0;
      for (int k = 0; k < 6; k++) begin
         drive(1'b0,1'b1,1'b0,1'b1,32'hA0 + k,1'b0);
         if (in_ready) n++;
         advance();
      end
      chk("bp_accepts", n, 4);
      drive(1'b0,1'b1,1'b0,1'b0,32'h0,1'b0);
      chk("bp_full_in_ready", in_ready, 1'b0);
      advance();
      got.delete();
      for (int k = 0; k < 12; k++) begin
         drive(1'b0,1'b1,1'b0,1'b0,32'h0,1'b1);
         if (out_valid) got.push_back(out_data);
         advance();
      end
      chk("bp_drain_count", got.size(), 4);
      for (int k = 0; k < 4; k++)
         chk("bp_drain_order", (got.size() > k) ? got[k] : 32'hFFFF_FFFF, 32'hA0 + k);

      // Full pipe with simultaneous accept and output.
      step(1'b1,1'b1,1'b0,1'b0,32'h0,1'b1);
      for (int k = 0; k < 4; k++) step(1'b0,1'b1,1'b0,1'b1,32'hB0 + k,1'b0);
      drive(1'b0,1'b1,1'b0,1'b1,32'hB4,1'b1);
      chk("full_pass_in_ready", in_ready, 1'b1);
      chk("full_pass_out_valid", out_valid, 1'b1);
      chk("full_pass_out_data", out_data, 32'hB0);
      advance();
      drive(1'b0,1'b1,1'b0,1'b0,32'h0,1'b0);
      chk("full_after_in_ready", in_ready, 1'b0);
      chk("full_after_out_data", out_data, 32'hB1);
`ifdef REG_PIPE_OCC_EN
      chk("full_after_occ", occ, 4);
`endif
      advance();

      // Flush with 3 words held and a word offered in the same cycle.
      step(1'b1,1'b1,1'b0,1'b0,32'h0,1'b1);
      for (int k = 0; k < 3; k++) step(1'b0,1'b1,1'b0,1'b1,32'hC0 + k,1'b0);
      step(1'b0,1'b1,1'b1,1'b1,32'hC9,1'b0);
      drive(1'b0,1'b1,1'b0,1'b0,32'h0,1'b1);
      chk("flush_out_valid", out_valid, 1'b0);
`ifdef REG_PIPE_OCC_EN
      chk("flush_occ", occ, 0);
`endif
      advance();
      for (int k = 0; k < 8; k++) begin
         drive(1'b0,1'b1,1'b0,1'b0,32'h0,1'b1);
         chk("flush_no_ghost", out_valid, 1'b0);
         advance();
      end

      // Enable low for 5 cycles mid-stream.
      step(1'b1,1'b1,1'b0,1'b0,32'h0,1'b1);
      got.delete();
      exp34.delete();
      for (int k = 0; k < 20; k++) if (k < 6 || k > 10) exp34.push_back(32'hD0 + k);
      for (int k = 0; k < 20; k++) begin
         bit e;
         e = !(k >= 6 && k <= 10);
         drive(1'b0,e,1'b0,1'b1,32'hD0 + k,1'b1);
         if (!e) chk("en_low_in_ready", in_ready, 1'b0);
         if (e && out_valid) got.push_back(out_data);
         advance();
      end
      for (int k = 0; k < 10; k++) begin
         drive(1'b0,1'b1,1'b0,1'b0,32'h0,1'b1);
         if (out_valid) got.push_back(out_data);
         advance();
      end
      chk("en_stream_count", got.size(), 15);
      for (int k = 0; k < 15; k++)
         chk("en_stream_order", (got.size() > k) ? got[k] : 32'hFFFF_FFFF, exp34[k]);

      // Reset while full.
      step(1'b1,1'b1,1'b0,1'b0,32'h0,1'b1);
      for (int k = 0; k < 4; k++) step(1'b0,1'b1,1'b0,1'b1,32'hE0 + k,1'b0);
      step(1'b1,1'b1,1'b0,1'b1,32'hEE,1'b1);
      drive(1'b0,1'b1,1'b0,1'b0,32'h0,1'b0);
      chk("rst_full_out_valid", out_valid, 1'b0);
      chk("rst_full_out_data", out_data, 32'hDEAD);
`ifdef REG_PIPE_OCC_EN
      chk("rst_full_occ", occ, 0);
`endif
      advance();

      // Randomized traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         step($urandom_range(199) == 0,
              $urandom_range(9) != 0,
              $urandom_range(39) == 0,
              $urandom_range(9) < 7,
              $urandom,
              $urandom_range(9) < 6);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
